// File: rtl/rms_estimator.sv
// Windowed RMS estimator: square, sum over 2**LOG2_WIN samples, divide, then
// a bit-serial restoring integer square root publishing one value per window.
module rms_estimator #(
  parameter int SAMPLE_W = 16,
  parameter int LOG2_WIN = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_sample,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] out_rms_val,
  output logic                busy
);

  localparam int SQ_W  = 2 * SAMPLE_W;
  localparam int ACC_W = SQ_W + LOG2_WIN;
  localparam int REM_W = SQ_W + 2;
  localparam int IT_W  = $clog2(SAMPLE_W);
  localparam logic [IT_W-1:0] LAST_IT = IT_W'(SAMPLE_W - 1);

  typedef enum logic {IDLE, SQRT} state_t;

  state_t state, state_nxt;

  logic signed [SQ_W-1:0] smp_ext, sq_prod;
  logic [SQ_W-1:0]        sq;
  logic                   sq_valid;
  logic [ACC_W-1:0]       acc, acc_sum;
  logic [LOG2_WIN-1:0]    cnt;
  logic                   win_close;

  logic [SQ_W-1:0]     rad;
  logic [REM_W-1:0]    rem, rem_sh, trial, rem_nxt;
  logic [SAMPLE_W-1:0] root, root_nxt;
  logic [IT_W-1:0]     iter;
  logic                last_iter;
  logic                rem_unused;

  // Sign-extend to full product width so the most negative sample squares correctly.
  assign smp_ext = signed'({{SAMPLE_W{in_sample[SAMPLE_W-1]}}, in_sample});
  assign sq_prod = smp_ext * smp_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq       <= '0;
      sq_valid <= 1'b0;
    end else begin
      sq_valid <= in_valid;
      if (in_valid) sq <= sq_prod;
    end
  end

  assign acc_sum   = acc + ACC_W'(sq);
  assign win_close = sq_valid && (cnt == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (sq_valid) begin
      if (win_close) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc_sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // FSM: state register / next-state / outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (win_close)         state_nxt = SQRT;
      SQRT: if (iter == LAST_IT)   state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == SQRT);
    last_iter = (state == SQRT) && (iter == LAST_IT);
  end

  // One root bit per cycle: bring down two radicand bits, try (root<<2)|1.
  assign rem_unused = ^rem[REM_W-1 -: 2];
  assign rem_sh     = {rem[REM_W-3:0], rad[SQ_W-1 -: 2]};
  assign trial      = {{(REM_W-SAMPLE_W-2){1'b0}}, root, 2'b01};

  always_comb begin
    rem_nxt  = rem_sh;
    root_nxt = {root[SAMPLE_W-2:0], 1'b0};
    if (rem_sh >= trial) begin
      rem_nxt  = rem_sh - trial;
      root_nxt = {root[SAMPLE_W-2:0], 1'b1};
    end
  end

  // A window cannot close while busy since a window outlasts the root.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rad  <= '0;
      rem  <= '0;
      root <= '0;
      iter <= '0;
    end else if (win_close) begin
      rad  <= acc_sum[ACC_W-1:LOG2_WIN];
      rem  <= '0;
      root <= '0;
      iter <= '0;
    end else if (busy) begin
      rad  <= rad << 2;
      rem  <= rem_nxt;
      root <= root_nxt;
      iter <= iter + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_rms_val <= '0;
    end else begin
      out_valid <= last_iter;
      if (last_iter) out_rms_val <= root_nxt;
    end
  end

endmodule

// File: tb/tb_rms_estimator.sv
// Directed bench for rms_estimator: known windows with hand-computed RMS,
// latency, pulse width, back-to-back windows and asynchronous reset.
module tb_rms_estimator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_sample;
  logic        out_valid;
  logic [15:0] out_rms_val;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] smp [0:127];

  rms_estimator #(.SAMPLE_W(16), .LOG2_WIN(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample),
    .out_valid(out_valid), .out_rms_val(out_rms_val), .busy(busy)
  );

  always #5 clk = ~clk;

  // Present n samples from smp[], one per edge, optionally with random idle cycles.
  task automatic feed(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid  = 1'b1;
      in_sample = smp[i];
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Edges after the last accepted sample until out_valid is seen (-1 on timeout).
  task automatic wait_pulse(output int lat);
    lat = -1;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sample = '0;
    #12;
    n_chk++;
    if (out_valid !== 1'b0 || out_rms_val !== 16'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b rms=%0d busy=%b, need 0/0/0", out_valid, out_rms_val, busy);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_dc();
    int lat;
    for (int i = 0; i < 64; i++) smp[i] = 16'd100;
    feed(64, 0);
    wait_pulse(lat);
    n_chk++;
    if (lat !== 17) begin
      n_fail++; $display("FAIL dc_latency: got %0d, need 17", lat);
    end
    n_chk++;
    if (out_rms_val !== 16'd100) begin
      n_fail++; $display("FAIL dc_value: got %0d, need 100", out_rms_val);
    end
    @(posedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b0 || out_rms_val !== 16'd100 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL dc_pulse_width: got valid=%b rms=%0d busy=%b, need 0/100/0", out_valid, out_rms_val, busy);
    end
  endtask

  task automatic test_alternating();
    int lat;
    for (int i = 0; i < 64; i++) smp[i] = (i % 2 == 0) ? 16'd1000 : -16'sd1000;
    feed(64, 0);
    wait_pulse(lat);
    n_chk++;
    if (lat !== 17 || out_rms_val !== 16'd1000) begin
      n_fail++; $display("FAIL alt_sign: got lat=%0d rms=%0d, need 17/1000", lat, out_rms_val);
    end
  endtask

  task automatic test_neg_full_scale();
    int lat;
    for (int i = 0; i < 64; i++) smp[i] = 16'h8000;
    feed(64, 0);
    wait_pulse(lat);
    n_chk++;
    if (lat !== 17 || out_rms_val !== 16'h8000) begin
      n_fail++; $display("FAIL neg_full_scale: got lat=%0d rms=%h, need 17/8000", lat, out_rms_val);
    end
  endtask

  task automatic test_gaps();
    int lat;
    for (int i = 0; i < 64; i++) smp[i] = (i < 32) ? 16'd3 : 16'd4;
    feed(64, 1);
    wait_pulse(lat);
    n_chk++;
    if (lat !== 17) begin
      n_fail++; $display("FAIL gaps_latency: got %0d, need 17", lat);
    end
    n_chk++;
    if (out_rms_val !== 16'd3) begin
      n_fail++; $display("FAIL gaps_value: got %0d, need 3", out_rms_val);
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0, np = 0, overlap = 0;
    int t0 = 0, t1 = 0;
    logic [15:0] v0 = '1, v1 = '1;
    for (int i = 0; i < 128; i++) smp[i] = (i < 64) ? 16'd0 : 16'd7;
    fork
      feed(128, 0);
      begin
        for (int e = 0; e < 250 && np < 2; e++) begin
          @(posedge clk); #1;
          cyc++;
          if (busy === 1'b1 && in_valid === 1'b1) overlap++;
          if (out_valid === 1'b1) begin
            if (np == 0) begin t0 = cyc; v0 = out_rms_val; end
            else         begin t1 = cyc; v1 = out_rms_val; end
            np++;
          end
        end
      end
    join
    n_chk++;
    if (np != 2) begin
      n_fail++; $display("FAIL b2b_pulses: got %0d, need 2", np);
    end
    n_chk++;
    if (v0 !== 16'd0 || v1 !== 16'd7) begin
      n_fail++; $display("FAIL b2b_values: got %0d,%0d, need 0,7", v0, v1);
    end
    n_chk++;
    if (t1 - t0 != 64) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d, need 64", t1 - t0);
    end
    n_chk++;
    if (overlap < 10) begin
      n_fail++; $display("FAIL b2b_overlap: got %0d busy+sample cycles, need >=10", overlap);
    end
  endtask

  task automatic test_reset_mid_sqrt();
    int lat, seen;
    // Close a window and keep feeding the next one so the root is in flight.
    for (int i = 0; i < 74; i++) smp[i] = 16'd9;
    feed(74, 0);
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre_busy: got %b, need 1", busy);
    end
    @(negedge clk); #2 rst = 1'b1; #1;
    n_chk++;
    if (out_valid !== 1'b0 || out_rms_val !== 16'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_sqrt: got valid=%b rms=%0d busy=%b, need 0/0/0", out_valid, out_rms_val, busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid === 1'b1) seen++; end
    n_chk++;
    if (seen != 0) begin
      n_fail++; $display("FAIL rst_no_pulse: got %0d pulses, need 0", seen);
    end
    // Partial window of 40 samples, then reset between edges.
    feed(40, 0);
    @(negedge clk); #3 rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 64; i++) smp[i] = 16'd5;
    feed(64, 0);
    wait_pulse(lat);
    n_chk++;
    if (lat !== 17 || out_rms_val !== 16'd5) begin
      n_fail++; $display("FAIL rst_recover: got lat=%0d rms=%0d, need 17/5", lat, out_rms_val);
    end
  endtask

  initial begin
    test_reset();
    test_dc();
    test_alternating();
    test_neg_full_scale();
    test_gaps();
    test_back_to_back();
    test_reset_mid_sqrt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
